recon_ctrl: RTL and testbench

- Central reconfiguration controller for one reconfigurable region (RR) hosting swappable cores such as reverse, each with a filter_sync rc_reqn/rc_ackn port.
- On a software request it sequences the RR through five steps: quiesce the resident core, isolate the RR, start the bitstream loader, reset the new core, then release the RR.
- Sits between the host/register interface, the ICAP loader and the RR boundary.

---
 rtl/recon_pkg.sv | 18 +
 rtl/recon_timer.sv | 15 +
 rtl/recon_ctrl.sv | 131 +++++++++++++
 tb/tb_recon_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/recon_pkg.sv
// recon_pkg: shared FSM state encoding and error codes for the reconfiguration controller
package recon_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_QUIESCE   = 4'd1,
    S_ISOLATE   = 4'd2,
    S_LOAD_REQ  = 4'd3,
    S_LOAD_WAIT = 4'd4,
    S_RESET     = 4'd5,
    S_RELEASE   = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } state_t;
  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_QTO   = 2'd1;
  localparam logic [1:0] E_LDERR = 2'd2;
  localparam logic [1:0] E_RTO   = 2'd3;
endpackage

// File: rtl/recon_timer.sv
// recon_timer: clearable saturating up-counter with terminal-count compare
module recon_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] tc,
  output logic         hit
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (&cnt_q ? cnt_q : cnt_q + W'(1));
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign hit = cnt_q == tc;
endmodule

// File: rtl/recon_ctrl.sv
// recon_ctrl: sequences one reconfigurable region through quiesce, isolate, load, reset and release
module recon_ctrl
  import recon_pkg::*;
#(
  parameter int C_ID_BW       = 8,
  parameter int C_ACK_TIMEOUT = 1024,
  parameter int C_RST_CYCLES  = 16,
  parameter int C_SKIP_SAME   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_req,
  input  logic [C_ID_BW-1:0] sw_mod_id,
  output logic               sw_busy,
  output logic               sw_done,
  output logic               sw_err,
  output logic [1:0]         sw_err_code,
  output logic               rc_reqn,
  input  logic               rc_ackn,
  output logic               iso_en,
  output logic               rr_rst,
  output logic               ld_start,
  output logic [C_ID_BW-1:0] ld_mod_id,
  input  logic               ld_done,
  input  logic               ld_err,
  output logic [C_ID_BW-1:0] cur_mod_id
);
  localparam int TW = $clog2(C_ACK_TIMEOUT);
  localparam logic [TW-1:0] T_ACK = TW'(C_ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_RST = TW'(C_RST_CYCLES - 1);
  state_t state_q, state_d;
  logic [C_ID_BW-1:0] tgt_q, tgt_d, cur_q, cur_d, ld_id_q, ld_id_d;
  logic [1:0] code_q, code_d;
  logic fence_q, fence_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic reqn_q, reqn_d, iso_q, iso_d, rr_q, rr_d, lds_q, lds_d;
  logic clr, hit;
  recon_timer #(.W(TW)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tc  (state_q == S_RESET ? T_RST : T_ACK),
    .hit (hit)
  );
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    ld_id_d = ld_id_q;
    code_d  = code_q;
    fence_d = fence_q;
    case (state_q)
      S_IDLE: if (sw_req) begin
        tgt_d   = sw_mod_id;
        code_d  = E_NONE;
        fence_d = 1'b0;
        state_d = (C_SKIP_SAME != 0 && sw_mod_id == cur_q && !fence_q) ? S_DONE : S_QUIESCE;
      end
      S_QUIESCE: begin
        state_d = !rc_ackn ? S_ISOLATE : (hit ? S_ERR : S_QUIESCE);
        code_d  = (rc_ackn && hit) ? E_QTO : code_q;
      end
      S_ISOLATE: begin
        state_d = S_LOAD_REQ;
        ld_id_d = tgt_q;
      end
      S_LOAD_REQ: state_d = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        state_d = ld_err ? S_ERR : (ld_done ? S_RESET : S_LOAD_WAIT);
        code_d  = ld_err ? E_LDERR : code_q;
        fence_d = ld_err;
        cur_d   = (ld_done && !ld_err) ? tgt_q : cur_q;
      end
      S_RESET: state_d = hit ? S_RELEASE : S_RESET;
      S_RELEASE: begin
        state_d = rc_ackn ? S_DONE : (hit ? S_ERR : S_RELEASE);
        code_d  = (!rc_ackn && hit) ? E_RTO : code_q;
      end
      default: state_d = S_IDLE;
    endcase
    clr    = state_d != state_q;
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
    err_d  = state_d == S_ERR;
    reqn_d = !(state_d inside {S_QUIESCE, S_ISOLATE, S_LOAD_REQ, S_LOAD_WAIT, S_RESET});
    iso_d  = (state_d inside {S_ISOLATE, S_LOAD_REQ, S_LOAD_WAIT, S_RESET}) || fence_d;
    rr_d   = state_d == S_RESET || fence_d;
    lds_d  = state_d == S_LOAD_REQ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      cur_q   <= '0;
      ld_id_q <= '0;
      code_q  <= E_NONE;
      fence_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      reqn_q  <= 1'b1;
      iso_q   <= 1'b0;
      rr_q    <= 1'b0;
      lds_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      ld_id_q <= ld_id_d;
      code_q  <= code_d;
      fence_q <= fence_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      reqn_q  <= reqn_d;
      iso_q   <= iso_d;
      rr_q    <= rr_d;
      lds_q   <= lds_d;
    end
  end
  assign sw_busy     = busy_q;
  assign sw_done     = done_q;
  assign sw_err      = err_q;
  assign sw_err_code = code_q;
  assign rc_reqn     = reqn_q;
  assign iso_en      = iso_q;
  assign rr_rst      = rr_q;
  assign ld_start    = lds_q;
  assign ld_mod_id   = ld_id_q;
  assign cur_mod_id  = cur_q;
endmodule

// File: tb/tb_recon_ctrl.sv
// tb_recon_ctrl: directed scenarios checked every cycle against a timing-window model of the controller
module tb_recon_ctrl;
  localparam int T = 1024;
  localparam int R = 16;
  localparam int N = 2210;
  logic clk = 1'b0;
  logic rst, sw_req, rc_ackn, ld_done, ld_err;
  logic [7:0] sw_mod_id, ld_mod_id, cur_mod_id;
  logic sw_busy, sw_done, sw_err, rc_reqn, iso_en, rr_rst, ld_start;
  logic [1:0] sw_err_code;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int exp_v [N][10];
  bit in_rst [N];
  bit in_req [N];
  bit in_ackn [N];
  bit in_done [N];
  bit in_err [N];
  int in_id [N];
  int pin_c [$];
  int pin_s [$];
  int pin_v [$];
  int m_cur, m_code, m_fence, m_ldid;
  string nm [10] = '{"sw_busy", "sw_done", "sw_err", "sw_err_code", "rc_reqn", "iso_en", "rr_rst", "ld_start", "ld_mod_id", "cur_mod_id"};
  recon_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .sw_req      (sw_req),
    .sw_mod_id   (sw_mod_id),
    .sw_busy     (sw_busy),
    .sw_done     (sw_done),
    .sw_err      (sw_err),
    .sw_err_code (sw_err_code),
    .rc_reqn     (rc_reqn),
    .rc_ackn     (rc_ackn),
    .iso_en      (iso_en),
    .rr_rst      (rr_rst),
    .ld_start    (ld_start),
    .ld_mod_id   (ld_mod_id),
    .ld_done     (ld_done),
    .ld_err      (ld_err),
    .cur_mod_id  (cur_mod_id)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int sig(int s);
    case (s)
      0: return int'(sw_busy);
      1: return int'(sw_done);
      2: return int'(sw_err);
      3: return int'(sw_err_code);
      4: return int'(rc_reqn);
      5: return int'(iso_en);
      6: return int'(rr_rst);
      7: return int'(ld_start);
      8: return int'(ld_mod_id);
      default: return int'(cur_mod_id);
    endcase
  endfunction
  task automatic chk(string n, int got, int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", n, got, want);
    end
  endtask
  task automatic put(int c, bit b, bit d, bit e, bit rq, bit iso, bit rr, bit ls);
    exp_v[c][0] = b;
    exp_v[c][1] = d;
    exp_v[c][2] = e;
    exp_v[c][3] = m_code;
    exp_v[c][4] = rq;
    exp_v[c][5] = iso;
    exp_v[c][6] = rr;
    exp_v[c][7] = ls;
    exp_v[c][8] = m_ldid;
    exp_v[c][9] = m_cur;
  endtask
  task automatic idle_from(int c);
    for (int i = c; i < N; i++) put(i, 0, 0, 0, 1, m_fence[0], m_fence[0], 0);
  endtask
  task automatic ackn_low(int from, int to);
    for (int i = from; i <= to; i++) in_ackn[i] = 1'b0;
  endtask
  // request in cycle a; core acks ackd cycles after rc_reqn falls (>=T: never),
  // loader answers L cycles after ld_start, core releases reld cycles after rc_reqn rises (>=T: never)
  task automatic txn(int a, int id, int ackd, int l, bit fail, int reld);
    int q, k, s, r;
    in_req[a] = 1'b1;
    in_id[a]  = id;
    m_code = 0;
    if (id == m_cur && m_fence == 0) begin
      put(a + 1, 1, 1, 0, 1, 0, 0, 0);
      idle_from(a + 2);
      return;
    end
    m_fence = 0;
    q = a + 1;
    if (ackd >= T) begin
      for (int i = q; i < q + T; i++) put(i, 1, 0, 0, 0, 0, 0, 0);
      m_code = 1;
      put(q + T, 1, 0, 1, 1, 0, 0, 0);
      idle_from(q + T + 1);
      return;
    end
    k = q + ackd;
    for (int i = q; i <= k; i++) put(i, 1, 0, 0, 0, 0, 0, 0);
    put(k + 1, 1, 0, 0, 0, 1, 0, 0);
    m_ldid = id;
    s = k + 2;
    put(s, 1, 0, 0, 0, 1, 0, 1);
    for (int i = s + 1; i <= s + l; i++) put(i, 1, 0, 0, 0, 1, 0, 0);
    in_done[s + l] = 1'b1;
    in_err[s + l]  = fail;
    if (fail) begin
      m_code  = 2;
      m_fence = 1;
      put(s + l + 1, 1, 0, 1, 1, 1, 1, 0);
      idle_from(s + l + 2);
      ackn_low(k, s + l);
      return;
    end
    m_cur = id;
    for (int i = s + l + 1; i <= s + l + R; i++) put(i, 1, 0, 0, 0, 1, 1, 0);
    r = s + l + R + 1;
    if (reld >= T) begin
      for (int i = r; i < r + T; i++) put(i, 1, 0, 0, 1, 0, 0, 0);
      m_code = 3;
      put(r + T, 1, 0, 1, 1, 0, 0, 0);
      idle_from(r + T + 1);
      ackn_low(k, r + T);
      return;
    end
    for (int i = r; i <= r + reld; i++) put(i, 1, 0, 0, 1, 0, 0, 0);
    put(r + reld + 1, 1, 1, 0, 1, 0, 0, 0);
    idle_from(r + reld + 2);
    ackn_low(k, r + reld - 1);
  endtask
  task automatic hard_reset(int c);
    in_rst[c] = 1'b1;
    m_cur = 0;
    m_code = 0;
    m_fence = 0;
    m_ldid = 0;
    idle_from(c + 1);
    for (int i = c + 1; i < N; i++) in_ackn[i] = 1'b1;
  endtask
  task automatic pin(int c, int s, int v);
    pin_c.push_back(c);
    pin_s.push_back(s);
    pin_v.push_back(v);
  endtask
  task automatic drive(int c);
    rst       = in_rst[c];
    sw_req    = in_req[c];
    sw_mod_id = 8'(in_id[c]);
    rc_ackn   = in_ackn[c];
    ld_done   = in_done[c];
    ld_err    = in_err[c];
  endtask
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      for (int s = 0; s < 10; s++) chk($sformatf("%s@%0d", nm[s], cyc), sig(s), exp_v[cyc][s]);
      for (int i = 0; i < pin_c.size(); i++)
        if (pin_c[i] == cyc) chk($sformatf("pin_%s@%0d", nm[pin_s[i]], cyc), sig(pin_s[i]), pin_v[i]);
    end
  end
  initial begin
    foreach (in_ackn[i]) in_ackn[i] = 1'b1;
    in_rst[0] = 1'b1;
    in_rst[1] = 1'b1;
    m_cur = 0;
    m_code = 0;
    m_fence = 0;
    m_ldid = 0;
    idle_from(1);
    txn(5, 2, 3, 20, 1'b0, 1);
    txn(55, 2, 0, 0, 1'b0, 0);
    txn(60, 5, T, 0, 1'b0, 0);
    txn(1090, 7, 0, 4, 1'b1, 0);
    txn(1105, 2, 1, 3, 1'b0, 0);
    in_req[1110] = 1'b1;
    in_id[1110]  = 9;
    in_req[1111] = 1'b1;
    in_id[1111]  = 9;
    txn(1135, 4, 0, 2, 1'b0, 0);
    hard_reset(1145);
    txn(1150, 3, 0, 1, 1'b0, T);
    txn(2200, 3, 0, 0, 1'b0, 0);
    pin(1, 0, 0);
    pin(1, 4, 1);
    pin(1, 3, 0);
    pin(11, 7, 1);
    pin(11, 8, 2);
    pin(31, 6, 0);
    pin(32, 6, 1);
    pin(47, 6, 1);
    pin(48, 6, 0);
    pin(50, 1, 1);
    pin(50, 9, 2);
    pin(56, 1, 1);
    pin(56, 4, 1);
    pin(1084, 2, 0);
    pin(1085, 2, 1);
    pin(1085, 3, 1);
    pin(1085, 4, 1);
    pin(1098, 2, 1);
    pin(1098, 3, 2);
    pin(1098, 9, 2);
    pin(1104, 5, 1);
    pin(1104, 6, 1);
    pin(1106, 4, 0);
    pin(1109, 7, 1);
    pin(1130, 1, 1);
    pin(1146, 0, 0);
    pin(1146, 4, 1);
    pin(1146, 5, 0);
    pin(1146, 6, 0);
    pin(1146, 9, 0);
    pin(2195, 2, 1);
    pin(2195, 3, 3);
    pin(2201, 1, 1);
    drive(0);
    while (cyc < N - 1) begin
      @(posedge clk);
      #1;
      drive(cyc);
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
